// File: rtl/ext_bus_ctrl_pkg.sv
// ext_bus_pkg: shared types and constants for the external bus-cycle
// controller (state encoding, region decode, counter widths, IO timeout).
// The IO-ready timeout constants are only used when EXT_BUS_IO_READY_EN
// is defined.
package ext_bus_pkg;

  // Bus-cycle sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_e;

  // Address regions selected by the decoder
  typedef enum logic {
    REGION_SRAM = 1'b0,
    REGION_IO   = 1'b1
  } region_e;

  // Strobe wait counter width (wait counts 0..15)
  localparam int CNT_W = 4;

  // IO-ready timeout: cycles spent stalled at count 0 before the cycle is forced to end
  localparam int TIMEOUT_CYCLES = 256;
  localparam int TMO_W          = 9;

  // The IO page is one 4 KB page selected by the top address nibble
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic [3:0]  io_page);
    region_e r;
    if (addr[15:12] == io_page) begin
      r = REGION_IO;
    end else begin
      r = REGION_SRAM;
    end
    return r;
  endfunction

endpackage

// File: rtl/ext_bus_ctrl_if.sv
// ext_bus_ctrl_if: core-side strobes plus SRAM/IO-side bus of the external
// bus-cycle controller. IO_RDYN exists only when EXT_BUS_IO_READY_EN is
// defined. The controller uses the slave modport; whatever drives the core
// pins and models the memory uses the master modport.
interface ext_bus_ctrl_if;

  // core side
  logic [15:0] ADDR_BUF;
  logic [15:0] DOUT_BUF;
  logic        RDN_BUF;
  logic        WRN0_BUF;
  logic        WRN1_BUF;
  logic        ABUS_OEN;
  logic [15:0] DIN;
  logic        WAIT;
  logic        BUS_ERR;

  // memory / IO side
  logic [14:0] MEM_A;
  logic [15:0] MEM_DOUT;
  logic [15:0] MEM_DIN;
  logic        MEM_DOE;
  logic        MEM_CEN;
  logic        IO_CEN;
  logic        MEM_OEN;
  logic        MEM_WEN;
  logic        MEM_LBN;
  logic        MEM_UBN;
`ifdef EXT_BUS_IO_READY_EN
  logic        IO_RDYN;
`endif

  modport slave (
    input  ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, MEM_DIN,
    output DIN, WAIT, BUS_ERR, MEM_A, MEM_DOUT, MEM_DOE, MEM_CEN, IO_CEN,
           MEM_OEN, MEM_WEN, MEM_LBN, MEM_UBN
`ifdef EXT_BUS_IO_READY_EN
    , input IO_RDYN
`endif
  );

  modport master (
    output ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, MEM_DIN,
    input  DIN, WAIT, BUS_ERR, MEM_A, MEM_DOUT, MEM_DOE, MEM_CEN, IO_CEN,
           MEM_OEN, MEM_WEN, MEM_LBN, MEM_UBN
`ifdef EXT_BUS_IO_READY_EN
    , output IO_RDYN
`endif
  );

endinterface

// File: rtl/ext_bus_ctrl_wait_ctr.sv
// ext_bus_wait_ctr: loadable strobe-width down-counter with zero flag.
// With EXT_BUS_IO_READY_EN defined it also counts stalled cycles and flags
// the IO-ready timeout on the last allowed stall cycle.
module ext_bus_wait_ctr
  import ext_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
`ifdef EXT_BUS_IO_READY_EN
  ,
  input  logic             stall,
  output logic             timeout
`endif
);

  logic [CNT_W-1:0] cnt_r;

  // Strobe wait counter: load at SETUP, count down to zero during STROBE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

`ifdef EXT_BUS_IO_READY_EN
  logic [TMO_W-1:0] tmo_r;

  // Stall cycle counter: cleared with each new cycle, advances while IO is not ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if (load) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if (stall && !timeout) begin
      tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // Raised during the final permitted stall cycle so the sequencer exits on that edge
  assign timeout = stall && (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

endmodule

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: converts the core's level bus strobes into sequenced
// SRAM/IO cycles (setup, parameterised strobe width, hold) with byte-lane
// enables, and stretches the core with WAIT while a cycle runs.
// Optional feature macro: EXT_BUS_IO_READY_EN adds IO_RDYN handshaking with
// a fixed timeout for IO-page cycles.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int unsigned WAIT_SRAM = 1,
  parameter int unsigned WAIT_IO   = 3,
  parameter logic [3:0]  IO_PAGE   = 4'hF
) (
  input logic           CLK,
  input logic           RESETN,
  ext_bus_ctrl_if.slave bus
);

  // sequencer state and latched cycle attributes
  bus_state_e  state_r;
  region_e     region_r;
  logic        is_write_r;
  logic [2:0]  strb_hist_r;

  // registered outputs
  logic [15:0] din_r;
  logic        wait_r;
  logic        bus_err_r;
  logic [14:0] mem_a_r;
  logic [15:0] mem_dout_r;
  logic        mem_doe_r;
  logic        mem_cen_r;
  logic        io_cen_r;
  logic        mem_oen_r;
  logic        mem_wen_r;
  logic        mem_lbn_r;
  logic        mem_ubn_r;

  // combinational decode
  logic [2:0]       strb_now_s;
  logic [2:0]       strb_fall_s;
  logic             req_s;
  logic             wr_req_s;
  logic             conflict_s;
  region_e          region_s;
  logic             ctr_load_s;
  logic [CNT_W-1:0] ctr_val_s;
  logic             ctr_dec_s;
  logic             ctr_zero_s;
  logic             unused_addr_s;
`ifdef EXT_BUS_IO_READY_EN
  logic             stall_s;
  logic             timeout_s;
`endif

  // address bit 0 selects a byte within the word and is carried by the lane strobes
  assign unused_addr_s = bus.ADDR_BUF[0];

  // Request detection, region decode and wait counter controls
  always_comb begin
    strb_now_s  = {bus.RDN_BUF, bus.WRN0_BUF, bus.WRN1_BUF};
    strb_fall_s = strb_hist_r & ~strb_now_s;
    req_s       = (strb_fall_s != 3'b000) && !bus.ABUS_OEN;
    wr_req_s    = !bus.WRN0_BUF || !bus.WRN1_BUF;
    conflict_s  = !bus.RDN_BUF && wr_req_s;
    region_s    = decode_region(bus.ADDR_BUF, IO_PAGE);
    ctr_load_s  = (state_r == SETUP);
    if (region_r == REGION_IO) begin
      ctr_val_s = CNT_W'(WAIT_IO);
    end else begin
      ctr_val_s = CNT_W'(WAIT_SRAM);
    end
    ctr_dec_s   = (state_r == STROBE) && !ctr_zero_s;
`ifdef EXT_BUS_IO_READY_EN
    stall_s     = (state_r == STROBE) && ctr_zero_s &&
                  (region_r == REGION_IO) && bus.IO_RDYN;
`endif
  end

  ext_bus_wait_ctr u_wait_ctr (
    .clk      (CLK),
    .rst_n    (RESETN),
    .load     (ctr_load_s),
    .load_val (ctr_val_s),
    .dec      (ctr_dec_s),
    .zero     (ctr_zero_s)
`ifdef EXT_BUS_IO_READY_EN
    ,
    .stall    (stall_s),
    .timeout  (timeout_s)
`endif
  );

  // Strobe history for edge detection; tracks the pins even mid-cycle so a
  // strobe held low across a cycle cannot retrigger until it returns high
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      strb_hist_r <= 3'b111;
    end else begin
      strb_hist_r <= strb_now_s;
    end
  end

  // Bus-cycle sequencer with all outputs registered
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r    <= IDLE;
      region_r   <= REGION_SRAM;
      is_write_r <= 1'b0;
      din_r      <= 16'h0000;
      wait_r     <= 1'b0;
      bus_err_r  <= 1'b0;
      mem_a_r    <= 15'h0000;
      mem_dout_r <= 16'h0000;
      mem_doe_r  <= 1'b0;
      mem_cen_r  <= 1'b1;
      io_cen_r   <= 1'b1;
      mem_oen_r  <= 1'b1;
      mem_wen_r  <= 1'b1;
      mem_lbn_r  <= 1'b1;
      mem_ubn_r  <= 1'b1;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_r    <= SETUP;
            wait_r     <= 1'b1;
            mem_a_r    <= bus.ADDR_BUF[15:1];
            mem_dout_r <= bus.DOUT_BUF;
            is_write_r <= wr_req_s;
            region_r   <= region_s;
            mem_doe_r  <= wr_req_s;
            // a simultaneous read and write strobe performs the write and flags it
            bus_err_r  <= conflict_s;
            mem_cen_r  <= (region_s == REGION_IO);
            io_cen_r   <= (region_s != REGION_IO);
            if (wr_req_s) begin
              mem_lbn_r <= bus.WRN0_BUF;
              mem_ubn_r <= bus.WRN1_BUF;
            end else begin
              mem_lbn_r <= 1'b0;
              mem_ubn_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          state_r <= STROBE;
          if (is_write_r) begin
            mem_wen_r <= 1'b0;
          end else begin
            mem_oen_r <= 1'b0;
          end
        end
        STROBE: begin
          if (!ctr_zero_s) begin
            state_r <= STROBE;
`ifdef EXT_BUS_IO_READY_EN
          end else if (stall_s && !timeout_s) begin
            state_r <= STROBE;
          end else if (stall_s) begin
            // IO device never became ready: end the cycle and report it
            state_r   <= HOLD;
            bus_err_r <= 1'b1;
            mem_oen_r <= 1'b1;
            mem_wen_r <= 1'b1;
            if (!is_write_r) begin
              din_r <= 16'hFFFF;
            end else begin
              din_r <= din_r;
            end
`endif
          end else begin
            state_r   <= HOLD;
            mem_oen_r <= 1'b1;
            mem_wen_r <= 1'b1;
            if (!is_write_r) begin
              din_r <= bus.MEM_DIN;
            end else begin
              din_r <= din_r;
            end
          end
        end
        HOLD: begin
          state_r   <= IDLE;
          wait_r    <= 1'b0;
          mem_doe_r <= 1'b0;
          mem_cen_r <= 1'b1;
          io_cen_r  <= 1'b1;
          mem_lbn_r <= 1'b1;
          mem_ubn_r <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          wait_r    <= 1'b0;
          mem_doe_r <= 1'b0;
          mem_cen_r <= 1'b1;
          io_cen_r  <= 1'b1;
          mem_oen_r <= 1'b1;
          mem_wen_r <= 1'b1;
          mem_lbn_r <= 1'b1;
          mem_ubn_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.DIN      = din_r;
  assign bus.WAIT     = wait_r;
  assign bus.BUS_ERR  = bus_err_r;
  assign bus.MEM_A    = mem_a_r;
  assign bus.MEM_DOUT = mem_dout_r;
  assign bus.MEM_DOE  = mem_doe_r;
  assign bus.MEM_CEN  = mem_cen_r;
  assign bus.IO_CEN   = io_cen_r;
  assign bus.MEM_OEN  = mem_oen_r;
  assign bus.MEM_WEN  = mem_wen_r;
  assign bus.MEM_LBN  = mem_lbn_r;
  assign bus.MEM_UBN  = mem_ubn_r;

endmodule
